// File: rtl/mem_access.sv
// mem_access: Y86 memory stage; runs data-memory req/ack transactions for EX/MEM and drives MEM/WB.
// Ports:
//   clk, rst (async, active-low)
//   mem_valid, mem_icode, mem_rA, mem_rB, mem_valA, mem_valP, mem_valE : EX/MEM fields
//   stall_req                                  : combinational hold for EX/MEM and upstream
//   dmem_req, dmem_we, dmem_addr, dmem_wdata   : registered data-memory request
//   dmem_ack, dmem_err, dmem_rdata             : data-memory completion
//   wb_valid, wb_icode, wb_rA, wb_rB, wb_valE, wb_valM, wb_stat : registered MEM/WB result
//   halted                                     : sticky after any non-AOK status
module mem_access #(
   parameter int TIMEOUT = 16,
   parameter int CNT_W   = 5
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        mem_valid,
   input  logic [7:0]  mem_icode,
   input  logic [7:0]  mem_rA,
   input  logic [7:0]  mem_rB,
   input  logic [31:0] mem_valA,
   input  logic [31:0] mem_valP,
   input  logic [31:0] mem_valE,
   output logic        stall_req,
   output logic        dmem_req,
   output logic        dmem_we,
   output logic [31:0] dmem_addr,
   output logic [31:0] dmem_wdata,
   input  logic        dmem_ack,
   input  logic        dmem_err,
   input  logic [31:0] dmem_rdata,
   output logic        wb_valid,
   output logic [7:0]  wb_icode,
   output logic [7:0]  wb_rA,
   output logic [7:0]  wb_rB,
   output logic [31:0] wb_valE,
   output logic [31:0] wb_valM,
   output logic [2:0]  wb_stat,
   output logic        halted
);
   localparam logic [2:0] ST_AOK = 3'd1;
   localparam logic [2:0] ST_HLT = 3'd2;
   localparam logic [2:0] ST_ADR = 3'd3;
   localparam logic [2:0] ST_INS = 3'd4;
   typedef enum logic [1:0] {IDLE, BUSY, HALTED} state_t;
   state_t state, state_nxt;
   logic [CNT_W-1:0] cnt;
   logic [3:0] op;
   logic is_inv, is_wr, is_rd, tmo;
   logic [31:0] req_addr, req_wdata;
   logic [2:0] idle_stat;
   // fields of the in-flight memory instruction, retired on ack/timeout
   logic [7:0] l_icode, l_rA, l_rB;
   logic [31:0] l_valE;
   logic l_rd;
   assign halted = (state == HALTED);
   always_comb begin
      op = mem_icode[3:0];
      is_inv = (mem_icode[7:4] != 4'h0) || (op > 4'hB);
      is_wr = !is_inv && (op == 4'h4 || op == 4'h8 || op == 4'hA);
      is_rd = !is_inv && (op == 4'h5 || op == 4'h9 || op == 4'hB);
      req_addr = (op == 4'h9 || op == 4'hB) ? mem_valA : mem_valE;
      req_wdata = (op == 4'h8) ? mem_valP : mem_valA;
      idle_stat = is_inv ? ST_INS : (op == 4'h0) ? ST_HLT : ST_AOK;
      // last allowed BUSY cycle without ack; stall is released here so upstream is not frozen
      tmo = (state == BUSY) && !dmem_ack && (cnt == CNT_W'(TIMEOUT - 1));
      stall_req = 1'b0;
      state_nxt = state;
      case (state)
         IDLE: begin
            stall_req = mem_valid && (is_wr || is_rd);
            if (mem_valid)
               state_nxt = (is_wr || is_rd) ? BUSY : (idle_stat != ST_AOK) ? HALTED : IDLE;
         end
         BUSY: begin
            stall_req = !dmem_ack && !tmo;
            state_nxt = dmem_ack ? (dmem_err ? HALTED : IDLE) : tmo ? HALTED : BUSY;
         end
         default: ;
      endcase
   end
   always_ff @(posedge clk or negedge rst)
      if (!rst) state <= IDLE;
      else state <= state_nxt;
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt <= '0;
         dmem_req <= 1'b0;
         dmem_we <= 1'b0;
         dmem_addr <= '0;
         dmem_wdata <= '0;
         wb_valid <= 1'b0;
         wb_icode <= '0;
         wb_rA <= '0;
         wb_rB <= '0;
         wb_valE <= '0;
         wb_valM <= '0;
         wb_stat <= ST_AOK;
         l_icode <= '0;
         l_rA <= '0;
         l_rB <= '0;
         l_valE <= '0;
         l_rd <= 1'b0;
      end else begin
         wb_valid <= 1'b0;
         case (state)
            IDLE: if (mem_valid) begin
               if (is_wr || is_rd) begin
                  dmem_req <= 1'b1;
                  dmem_we <= is_wr;
                  dmem_addr <= req_addr;
                  dmem_wdata <= req_wdata;
                  cnt <= '0;
                  l_icode <= mem_icode;
                  l_rA <= mem_rA;
                  l_rB <= mem_rB;
                  l_valE <= mem_valE;
                  l_rd <= is_rd;
               end else begin
                  wb_valid <= 1'b1;
                  wb_icode <= mem_icode;
                  wb_rA <= mem_rA;
                  wb_rB <= mem_rB;
                  wb_valE <= mem_valE;
                  wb_valM <= '0;
                  wb_stat <= idle_stat;
               end
            end
            BUSY: if (dmem_ack || tmo) begin
               dmem_req <= 1'b0;
               wb_valid <= 1'b1;
               wb_icode <= l_icode;
               wb_rA <= l_rA;
               wb_rB <= l_rB;
               wb_valE <= l_valE;
               wb_valM <= (dmem_ack && l_rd) ? dmem_rdata : '0;
               wb_stat <= (tmo || dmem_err) ? ST_ADR : ST_AOK;
            end else begin
               cnt <= cnt + 1'b1;
            end
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_mem_access.sv
// tb_mem_access: randomized and directed checks of mem_access against a spec-level model.
module tb_mem_access;
   localparam int TIMEOUT = 16;
   logic clk = 1'b0;
   logic rst = 1'b0;
   logic mem_valid = 1'b0;
   logic [7:0] mem_icode = '0, mem_rA = '0, mem_rB = '0;
   logic [31:0] mem_valA = '0, mem_valP = '0, mem_valE = '0;
   logic stall_req, dmem_req, dmem_we;
   logic [31:0] dmem_addr, dmem_wdata;
   logic dmem_ack = 1'b0, dmem_err = 1'b0;
   logic [31:0] dmem_rdata = '0;
   logic wb_valid, halted;
   logic [7:0] wb_icode, wb_rA, wb_rB;
   logic [31:0] wb_valE, wb_valM;
   logic [2:0] wb_stat;
   int n_chk = 0, n_pass = 0;
   logic [31:0] last_valE = '0;

   mem_access #(.TIMEOUT(TIMEOUT), .CNT_W(5)) dut (
      .clk(clk), .rst(rst), .mem_valid(mem_valid), .mem_icode(mem_icode),
      .mem_rA(mem_rA), .mem_rB(mem_rB), .mem_valA(mem_valA), .mem_valP(mem_valP),
      .mem_valE(mem_valE), .stall_req(stall_req), .dmem_req(dmem_req), .dmem_we(dmem_we),
      .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_ack(dmem_ack),
      .dmem_err(dmem_err), .dmem_rdata(dmem_rdata), .wb_valid(wb_valid),
      .wb_icode(wb_icode), .wb_rA(wb_rA), .wb_rB(wb_rB), .wb_valE(wb_valE),
      .wb_valM(wb_valM), .wb_stat(wb_stat), .halted(halted)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   // kind: 0 no memory, 1 read, 2 write; stat is the status when no memory access occurs
   function automatic void model(input logic [7:0] ic, input logic [31:0] va, vp, ve,
                                 output int kind, output logic [31:0] addr, wdata,
                                 output logic [2:0] stat);
      kind = 0; addr = '0; wdata = '0; stat = 3'd1;
      if (ic inside {8'h04, 8'h0A}) begin kind = 2; addr = ve; wdata = va; end
      else if (ic == 8'h08) begin kind = 2; addr = ve; wdata = vp; end
      else if (ic == 8'h05) begin kind = 1; addr = ve; end
      else if (ic inside {8'h09, 8'h0B}) begin kind = 1; addr = va; end
      else if (ic == 8'h00) stat = 3'd2;
      else if (ic > 8'h0B) stat = 3'd4;
   endfunction

   task automatic do_reset();
      rst = 1'b0;
      mem_valid = 1'b0;
      dmem_ack = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b1;
      #1;
      chk("rst_wb_valid", wb_valid, 0);
      chk("rst_dmem_req", dmem_req, 0);
      chk("rst_stat", wb_stat, 1);
      chk("rst_halted", halted, 0);
      chk("rst_stall", stall_req, 0);
      last_valE = '0;
   endtask

   // called at posedge+1; returns at posedge+1 of the cycle after retirement with mem_valid low
   task automatic do_op(input logic [7:0] ic, input logic [31:0] va, vp, ve,
                        input int wt, input logic [31:0] rd, input logic er);
      int kind;
      logic [31:0] addr, wdata;
      logic [2:0] st;
      logic tmo;
      model(ic, va, vp, ve, kind, addr, wdata, st);
      tmo = (kind != 0) && (wt >= TIMEOUT);
      mem_icode = ic; mem_valA = va; mem_valP = vp; mem_valE = ve;
      mem_rA = 8'($urandom); mem_rB = 8'($urandom); mem_valid = 1'b1;
      #1 chk("issue_stall", stall_req, kind != 0);
      @(posedge clk); #1;
      if (kind != 0) begin
         chk("req", dmem_req, 1);
         chk("we", dmem_we, kind == 2);
         chk("addr", dmem_addr, addr);
         if (kind == 2) chk("wdata", dmem_wdata, wdata);
         chk("no_early_wb", wb_valid, 0);
         for (int i = 0; i < (tmo ? TIMEOUT : wt); i++) begin
            #1 chk("busy_stall", stall_req, !(tmo && i == TIMEOUT - 1));
            @(posedge clk); #1;
            if (!(tmo && i == TIMEOUT - 1)) begin
               chk("hold_req", dmem_req, 1);
               chk("hold_addr", dmem_addr, addr);
            end
         end
         if (!tmo) begin
            dmem_ack = 1'b1; dmem_rdata = rd; dmem_err = er;
            #1 chk("ack_stall", stall_req, 0);
            @(posedge clk); #1;
            dmem_ack = 1'b0; dmem_err = 1'b0;
         end
      end
      mem_valid = 1'b0;
      chk("wb_valid", wb_valid, 1);
      chk("wb_icode", wb_icode, ic);
      chk("wb_rA", wb_rA, mem_rA);
      chk("wb_rB", wb_rB, mem_rB);
      chk("wb_valE", wb_valE, ve);
      chk("wb_valM", wb_valM, (kind == 1 && !tmo) ? rd : 32'h0);
      st = tmo ? 3'd3 : (kind != 0) ? (er ? 3'd3 : 3'd1) : st;
      chk("wb_stat", wb_stat, st);
      chk("halted", halted, st != 3'd1);
      chk("req_done", dmem_req, 0);
      last_valE = ve;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      do_reset();
      do_op(8'h06, 32'h0, 32'h0, 32'h1234, 0, 32'h0, 1'b0);
      @(posedge clk); #1;
      chk("strobe_drop", wb_valid, 0);
      chk("hold_valE", wb_valE, 32'h1234);
      do_op(8'h04, 32'hDEADBEEF, 32'h0, 32'h100, 3, 32'h0, 1'b0);
      do_op(8'h09, 32'h200, 32'h0, 32'h0, 0, 32'h55, 1'b0);
      do_op(8'h0B, 32'h300, 32'h0, 32'h0, 0, 32'h66, 1'b0);
      do_op(8'h08, 32'h1, 32'hCAFE, 32'h400, 1, 32'h0, 1'b0);
      for (int n = 0; n < 150; n++) begin
         do_op(8'($urandom_range(1, 11)), $urandom, $urandom, $urandom,
               $urandom_range(0, 3), $urandom, 1'b0);
         if ($urandom_range(0, 3) == 0) begin
            dmem_ack = 1'b1;
            @(posedge clk); #1;
            dmem_ack = 1'b0;
            chk("gap_wb_valid", wb_valid, 0);
            chk("gap_valE", wb_valE, last_valE);
            chk("gap_req", dmem_req, 0);
         end
      end
      do_op(8'h05, 32'h0, 32'h0, 32'h500, TIMEOUT, 32'h0, 1'b0);
      mem_icode = 8'h04; mem_valid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         #1 chk("halt_stall", stall_req, 0);
         @(posedge clk); #1;
         chk("halt_wb_valid", wb_valid, 0);
         chk("halt_req", dmem_req, 0);
         chk("halt_sticky", halted, 1);
      end
      do_reset();
      mem_icode = 8'h05; mem_valE = 32'h700; mem_valid = 1'b1;
      @(posedge clk); #1;
      chk("mid_req", dmem_req, 1);
      @(posedge clk); #2;
      rst = 1'b0;
      #1 chk("async_drop", dmem_req, 0);
      mem_valid = 1'b0;
      #1 rst = 1'b1;
      dmem_ack = 1'b1;
      @(posedge clk); #1;
      dmem_ack = 1'b0;
      chk("late_ack", wb_valid, 0);
      chk("late_ack_req", dmem_req, 0);
      do_op(8'h00, 32'h0, 32'h0, 32'h9, 0, 32'h0, 1'b0);
      do_reset();
      do_op(8'h0C, 32'h0, 32'h0, 32'hA, 0, 32'h0, 1'b0);
      do_reset();
      do_op(8'h16, 32'h0, 32'h0, 32'hB, 0, 32'h0, 1'b0);
      do_reset();
      do_op(8'h0A, 32'h77, 32'h0, 32'h800, 2, 32'h0, 1'b1);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
